// File: rtl/exec_sequencer.sv
// exec_sequencer
//
// Run controller between the instruction decoder and the accumulator
// datapath. It owns the start/done handshake with the harness and PC
// initialisation. It gates the decoder's write and memory enables so that
// every instruction commits exactly once. It freezes the PC while a
// data-memory access of fixed latency MEM_LAT is in flight. It also keeps
// saturating cycle and retired-instruction counters.
//
// Parameters
//   MEM_LAT  data-memory latency in cycles (0..15); 0 makes memory ops
//            single-cycle
//   CNT_W    width of cycle_count / instr_count
//
// Ports
//   CLK, Reset                 clock, asynchronous active-low reset
//   start                      level holds INIT; falling edge starts the run
//   dec_*                      raw decoder outputs for the current instruction
//   pc_init                    load PC with 0 (Moore, INIT)
//   pc_en                      advance PC (Mealy, retiring cycle only)
//   reg_we, acc_we             qualified write enables (Mealy)
//   mem_re, mem_we             qualified data-memory strobes (Mealy)
//   of_clr                     qualified overflow clear (Mealy)
//   stall                      access in progress, PC frozen
//   done                       program halted (Moore, DONE)
//   cycle_count                RUN/MEMWAIT cycles, saturating
//   instr_count                retired instructions incl. halt, saturating
module exec_sequencer #(
    parameter int MEM_LAT = 2,
    parameter int CNT_W   = 16
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             start,
    input  logic             dec_RegWrite,
    input  logic             dec_AccWrite,
    input  logic             dec_ReadMem,
    input  logic             dec_WriteMem,
    input  logic             dec_Halt,
    input  logic             dec_Branch,
    input  logic             dec_of0,
    output logic             pc_init,
    output logic             pc_en,
    output logic             reg_we,
    output logic             acc_we,
    output logic             mem_re,
    output logic             mem_we,
    output logic             of_clr,
    output logic             stall,
    output logic             done,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] INIT    = 3'd1;
    localparam logic [2:0] RUN     = 3'd2;
    localparam logic [2:0] MEMWAIT = 3'd3;
    localparam logic [2:0] DONE    = 3'd4;

    localparam logic [3:0]       LAT     = 4'(MEM_LAT);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [2:0]       stateReg, stateNext;
    logic [3:0]       waitCntReg, waitCntNext;
    logic [CNT_W-1:0] cycleCountReg, instrCountReg;
    logic             retire;
    logic             memOp;
    logic             unusedBranch;

    assign memOp = dec_ReadMem | dec_WriteMem;

    // Branch target selection lives in the PC; this block only decides
    // when pc_en fires, so the branch flag needs no qualification here.
    assign unusedBranch = dec_Branch;

    always_comb begin
        stateNext   = stateReg;
        waitCntNext = waitCntReg;
        retire      = 1'b0;
        pc_init     = 1'b0;
        pc_en       = 1'b0;
        reg_we      = 1'b0;
        acc_we      = 1'b0;
        mem_re      = 1'b0;
        mem_we      = 1'b0;
        of_clr      = 1'b0;
        stall       = 1'b0;
        done        = 1'b0;

        case (stateReg)
            IDLE: begin
                if (start) stateNext = INIT;
            end

            INIT: begin
                pc_init = 1'b1;
                if (!start) stateNext = RUN;
            end

            RUN: begin
                if (start) begin
                    // Abort: nothing commits this cycle.
                    stateNext = INIT;
                end else if (dec_Halt) begin
                    retire    = 1'b1;
                    stateNext = DONE;
                end else if (memOp && (LAT != 4'd0)) begin
                    // Issue the access; the store strobe fires only here.
                    mem_re      = dec_ReadMem;
                    mem_we      = dec_WriteMem;
                    stall       = 1'b1;
                    waitCntNext = 4'd1;
                    stateNext   = MEMWAIT;
                end else begin
                    reg_we = dec_RegWrite;
                    acc_we = dec_AccWrite;
                    mem_re = dec_ReadMem;
                    mem_we = dec_WriteMem;
                    of_clr = dec_of0;
                    pc_en  = 1'b1;
                    retire = 1'b1;
                end
            end

            MEMWAIT: begin
                // Stall depends on the wait count only, so it stays a
                // state output even on an abort cycle.
                stall = (waitCntReg != LAT);
                if (start) begin
                    waitCntNext = 4'd0;
                    stateNext   = INIT;
                end else if (waitCntReg != LAT) begin
                    mem_re      = dec_ReadMem;
                    waitCntNext = waitCntReg + 4'd1;
                end else begin
                    // Data is back: commit the load result and release the PC.
                    mem_re      = dec_ReadMem;
                    acc_we      = dec_AccWrite;
                    pc_en       = 1'b1;
                    retire      = 1'b1;
                    waitCntNext = 4'd0;
                    stateNext   = RUN;
                end
            end

            DONE: begin
                done = 1'b1;
                if (start) stateNext = INIT;
            end

            default: begin
                stateNext   = IDLE;
                waitCntNext = 4'd0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            stateReg      <= IDLE;
            waitCntReg    <= 4'd0;
            cycleCountReg <= '0;
            instrCountReg <= '0;
        end else begin
            stateReg   <= stateNext;
            waitCntReg <= waitCntNext;
            if (stateReg == INIT) begin
                cycleCountReg <= '0;
                instrCountReg <= '0;
            end else begin
                if (((stateReg == RUN) || (stateReg == MEMWAIT)) &&
                    (cycleCountReg != CNT_MAX)) begin
                    cycleCountReg <= cycleCountReg + CNT_ONE;
                end
                if (retire && (instrCountReg != CNT_MAX)) begin
                    instrCountReg <= instrCountReg + CNT_ONE;
                end
            end
        end
    end

    assign cycle_count = cycleCountReg;
    assign instr_count = instrCountReg;

endmodule

// File: tb/tb_exec_sequencer.sv
// Testbench for exec_sequencer. Instance A uses MEM_LAT=2, CNT_W=16.
// Instance B uses MEM_LAT=0, CNT_W=4.
module tb_exec_sequencer;

    // decoder bundle bit positions
    localparam int D_RW = 6, D_AW = 5, D_RM = 4, D_WM = 3, D_HALT = 2, D_BR = 1, D_OF = 0;
    // output bundle bit positions
    localparam int O_PCI = 8, O_PCE = 7, O_RW = 6, O_AW = 5, O_MR = 4, O_MW = 3, O_OF = 2, O_ST = 1, O_DN = 0;

    localparam logic [6:0] NOP   = 7'b0000000;
    localparam logic [6:0] LOAD  = 7'b0110000;
    localparam logic [6:0] STORE = 7'b0001000;
    localparam logic [6:0] HALT  = 7'b0000100;

    typedef struct packed {
        logic [8:0]  o;
        logic [15:0] c;
        logic [15:0] n;
    } snap_t;

    logic        CLK = 1'b0;
    logic        Reset = 1'b0;
    logic        startA = 1'b0, startB = 1'b0;
    logic [6:0]  decA = '0, decB = '0;
    logic [8:0]  outA, outB;
    logic [15:0] cycA, insA;
    logic [3:0]  cycB, insB;

    int checks = 0;
    int errors = 0;

    // Reference model: mode 0 idle, 1 init, 2 running, 3 done.
    // elapsed = cycles already spent on the current instruction.
    int mMode[2];
    int mElapsed[2];
    int mCyc[2];
    int mIns[2];
    int lat[2]  = '{2, 0};
    int cmax[2] = '{65535, 15};

    always #5 CLK = ~CLK;

    exec_sequencer #(.MEM_LAT(2), .CNT_W(16)) dutA (
        .CLK(CLK), .Reset(Reset), .start(startA),
        .dec_RegWrite(decA[D_RW]), .dec_AccWrite(decA[D_AW]), .dec_ReadMem(decA[D_RM]),
        .dec_WriteMem(decA[D_WM]), .dec_Halt(decA[D_HALT]), .dec_Branch(decA[D_BR]),
        .dec_of0(decA[D_OF]),
        .pc_init(outA[O_PCI]), .pc_en(outA[O_PCE]), .reg_we(outA[O_RW]), .acc_we(outA[O_AW]),
        .mem_re(outA[O_MR]), .mem_we(outA[O_MW]), .of_clr(outA[O_OF]), .stall(outA[O_ST]),
        .done(outA[O_DN]), .cycle_count(cycA), .instr_count(insA)
    );

    exec_sequencer #(.MEM_LAT(0), .CNT_W(4)) dutB (
        .CLK(CLK), .Reset(Reset), .start(startB),
        .dec_RegWrite(decB[D_RW]), .dec_AccWrite(decB[D_AW]), .dec_ReadMem(decB[D_RM]),
        .dec_WriteMem(decB[D_WM]), .dec_Halt(decB[D_HALT]), .dec_Branch(decB[D_BR]),
        .dec_of0(decB[D_OF]),
        .pc_init(outB[O_PCI]), .pc_en(outB[O_PCE]), .reg_we(outB[O_RW]), .acc_we(outB[O_AW]),
        .mem_re(outB[O_MR]), .mem_we(outB[O_MW]), .of_clr(outB[O_OF]), .stall(outB[O_ST]),
        .done(outB[O_DN]), .cycle_count(cycB), .instr_count(insB)
    );

    // Expected outputs for the cycle about to be clocked.
    function automatic logic [8:0] modelOut(input int i, input logic st, input logic [6:0] d);
        logic [8:0] o;
        logic       memOp;
        o = '0;
        memOp = d[D_RM] | d[D_WM];
        case (mMode[i])
            1: o[O_PCI] = 1'b1;
            3: o[O_DN] = 1'b1;
            2: begin
                if (mElapsed[i] > 0 && mElapsed[i] < lat[i]) o[O_ST] = 1'b1;
                if (!st) begin
                    if (mElapsed[i] == 0) begin
                        if (!d[D_HALT]) begin
                            if (memOp && lat[i] > 0) begin
                                o[O_MR] = d[D_RM];
                                o[O_MW] = d[D_WM];
                                o[O_ST] = 1'b1;
                            end else begin
                                o[O_RW]  = d[D_RW];
                                o[O_AW]  = d[D_AW];
                                o[O_MR]  = d[D_RM];
                                o[O_MW]  = d[D_WM];
                                o[O_OF]  = d[D_OF];
                                o[O_PCE] = 1'b1;
                            end
                        end
                    end else if (mElapsed[i] < lat[i]) begin
                        o[O_MR] = d[D_RM];
                    end else begin
                        o[O_MR]  = d[D_RM];
                        o[O_AW]  = d[D_AW];
                        o[O_PCE] = 1'b1;
                    end
                end
            end
            default: o = '0;
        endcase
        return o;
    endfunction

    task automatic modelStep(input int i, input logic st, input logic [6:0] d);
        case (mMode[i])
            0: if (st) mMode[i] = 1;
            1: begin
                mCyc[i] = 0;
                mIns[i] = 0;
                if (!st) begin
                    mMode[i] = 2;
                    mElapsed[i] = 0;
                end
            end
            2: begin
                if (mCyc[i] < cmax[i]) mCyc[i]++;
                if (st) begin
                    mMode[i] = 1;
                    mElapsed[i] = 0;
                end else if (mElapsed[i] == 0) begin
                    if (d[D_HALT]) begin
                        if (mIns[i] < cmax[i]) mIns[i]++;
                        mMode[i] = 3;
                    end else if ((d[D_RM] | d[D_WM]) && lat[i] > 0) begin
                        mElapsed[i] = 1;
                    end else begin
                        if (mIns[i] < cmax[i]) mIns[i]++;
                    end
                end else if (mElapsed[i] < lat[i]) begin
                    mElapsed[i]++;
                end else begin
                    if (mIns[i] < cmax[i]) mIns[i]++;
                    mElapsed[i] = 0;
                end
            end
            3: if (st) mMode[i] = 1;
            default: mMode[i] = 0;
        endcase
    endtask

    task automatic modelReset();
        for (int i = 0; i < 2; i++) begin
            mMode[i] = 0;
            mElapsed[i] = 0;
            mCyc[i] = 0;
            mIns[i] = 0;
        end
    endtask

    function automatic logic [6:0] randAlu();
        logic [6:0] d;
        d = 7'($urandom) & 7'b1100011;
        return d;
    endfunction

    // One clock cycle: drive at negedge, sample 1 time unit later, and
    // advance both models at the posedge.
    task automatic drive(input int i, input logic st, input logic [6:0] d,
                         output snap_t obs, output snap_t exp);
        @(negedge CLK);
        if (i == 0) begin
            startA = st;
            decA = d;
        end else begin
            startB = st;
            decB = d;
        end
        #1;
        if (i == 0) obs = {outA, cycA, insA};
        else        obs = {outB, 12'd0, cycB, 12'd0, insB};
        exp = {modelOut(i, st, d), 16'(mCyc[i]), 16'(mIns[i])};
        $display("[%s] t=%0t start=%b dec=%b out=%b cyc=%0d ins=%0d", (i == 0) ? "A" : "B",
                 $time, st, d, obs.o, obs.c, obs.n);
        @(posedge CLK);
        modelStep(0, startA, decA);
        modelStep(1, startB, decB);
    endtask

    // start for one cycle, then release it; leaves the machine running.
    task automatic launch(input int i);
        snap_t obs, exp;
        drive(i, 1'b1, NOP, obs, exp);
        drive(i, 1'b0, NOP, obs, exp);
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        startA = 1'b0; startB = 1'b0; decA = NOP; decB = NOP;
        modelReset();
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        #1;
        checks++;
        if (outA !== 9'd0 || cycA !== 16'd0 || insA !== 16'd0) begin
            errors++;
            $display("FAIL reset_A: got out=%b cyc=%0d ins=%0d want all 0", outA, cycA, insA);
        end
        checks++;
        if (outB !== 9'd0 || cycB !== 4'd0 || insB !== 4'd0) begin
            errors++;
            $display("FAIL reset_B: got out=%b cyc=%0d ins=%0d want all 0", outB, cycB, insB);
        end
        @(posedge CLK);
        #2 Reset = 1'b1;
    endtask

    task automatic test_idle();
        snap_t obs, exp;
        for (int k = 0; k < 5; k++) begin
            drive(0, 1'b0, NOP, obs, exp);
            checks++;
            if (obs !== exp || obs.o !== 9'd0) begin
                errors++;
                $display("FAIL idle cyc%0d: got %h want %h (outputs 0)", k, obs, exp);
            end
        end
    endtask

    task automatic test_start_run();
        snap_t obs, exp;
        int pci = 0;
        int pce = 0;
        for (int k = 0; k < 4; k++) begin
            drive(0, (k < 3), NOP, obs, exp);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL start cyc%0d: got %h want %h", k, obs, exp);
            end
            pci += int'(obs.o[O_PCI]);
        end
        for (int k = 0; k < 5; k++) begin
            drive(0, 1'b0, (k < 4) ? randAlu() : HALT, obs, exp);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL run cyc%0d: got %h want %h", k, obs, exp);
            end
            pce += int'(obs.o[O_PCE]);
        end
        drive(0, 1'b0, NOP, obs, exp);
        checks++;
        if (pci != 3) begin
            errors++;
            $display("FAIL pc_init_len: got %0d want 3", pci);
        end
        checks++;
        if (pce != 4) begin
            errors++;
            $display("FAIL pc_en_len: got %0d want 4", pce);
        end
        checks++;
        if (obs.o[O_DN] !== 1'b1 || obs.c !== 16'd5 || obs.n !== 16'd5) begin
            errors++;
            $display("FAIL halt_counts: got done=%b cyc=%0d ins=%0d want 1 5 5", obs.o[O_DN], obs.c, obs.n);
        end
    endtask

    task automatic test_mem(input logic [6:0] op, input logic [2:0] wantRe, input logic [2:0] wantWe,
                            input logic [2:0] wantAw);
        snap_t obs, exp;
        logic [2:0] re, we, aw, pe, stl;
        launch(0);
        for (int k = 0; k < 3; k++) begin
            drive(0, 1'b0, op, obs, exp);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL mem_op%b cyc%0d: got %h want %h", op, k, obs, exp);
            end
            re[k] = obs.o[O_MR]; we[k] = obs.o[O_MW]; aw[k] = obs.o[O_AW];
            pe[k] = obs.o[O_PCE]; stl[k] = obs.o[O_ST];
        end
        drive(0, 1'b0, HALT, obs, exp);
        checks++;
        if (obs !== exp || obs.n !== 16'd1 || obs.c !== 16'd3) begin
            errors++;
            $display("FAIL mem_retire: got %h want %h (ins 1 cyc 3)", obs, exp);
        end
        checks++;
        if (re !== wantRe || we !== wantWe || aw !== wantAw || pe !== 3'b100 || stl !== 3'b011) begin
            errors++;
            $display("FAIL mem_pulses: got re=%b we=%b aw=%b pe=%b st=%b want re=%b we=%b aw=%b pe=100 st=011",
                     re, we, aw, pe, stl, wantRe, wantWe, wantAw);
        end
    endtask

    task automatic test_zero_lat();
        snap_t obs, exp;
        launch(1);
        drive(1, 1'b0, LOAD, obs, exp);
        checks++;
        if (obs !== exp || obs.o[O_MR] !== 1'b1 || obs.o[O_AW] !== 1'b1 ||
            obs.o[O_PCE] !== 1'b1 || obs.o[O_ST] !== 1'b0) begin
            errors++;
            $display("FAIL zlat_load: got %h want %h", obs, exp);
        end
        drive(1, 1'b0, STORE, obs, exp);
        checks++;
        if (obs !== exp || obs.o[O_MW] !== 1'b1 || obs.o[O_PCE] !== 1'b1 || obs.o[O_ST] !== 1'b0) begin
            errors++;
            $display("FAIL zlat_store: got %h want %h", obs, exp);
        end
        drive(1, 1'b0, HALT, obs, exp);
        checks++;
        if (obs !== exp || obs.n !== 16'd2) begin
            errors++;
            $display("FAIL zlat_count: got %h want %h (ins 2)", obs, exp);
        end
    endtask

    task automatic test_abort();
        snap_t obs, exp;
        launch(0);
        drive(0, 1'b0, LOAD, obs, exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL abort_issue: got %h want %h", obs, exp);
        end
        drive(0, 1'b1, LOAD, obs, exp);
        checks++;
        if (obs !== exp || obs.o[O_AW] !== 1'b0 || obs.o[O_PCE] !== 1'b0 || obs.o[O_MR] !== 1'b0) begin
            errors++;
            $display("FAIL abort_cycle: got %h want %h (no enables)", obs, exp);
        end
        drive(0, 1'b0, NOP, obs, exp);
        checks++;
        if (obs !== exp || obs.o[O_PCI] !== 1'b1) begin
            errors++;
            $display("FAIL abort_init: got %h want %h (pc_init)", obs, exp);
        end
        drive(0, 1'b0, randAlu(), obs, exp);
        checks++;
        if (obs !== exp || obs.c !== 16'd0 || obs.n !== 16'd0) begin
            errors++;
            $display("FAIL abort_clear: got %h want %h (counters 0)", obs, exp);
        end
        drive(0, 1'b0, HALT, obs, exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL abort_halt: got %h want %h", obs, exp);
        end
    endtask

    task automatic test_saturate();
        snap_t obs, exp;
        launch(1);
        for (int k = 0; k < 21; k++) begin
            drive(1, 1'b0, (k < 20) ? randAlu() : HALT, obs, exp);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL sat cyc%0d: got %h want %h", k, obs, exp);
            end
        end
        drive(1, 1'b0, NOP, obs, exp);
        checks++;
        if (obs.o[O_DN] !== 1'b1 || obs.c !== 16'd15 || obs.n !== 16'd15) begin
            errors++;
            $display("FAIL sat_final: got done=%b cyc=%0d ins=%0d want 1 15 15", obs.o[O_DN], obs.c, obs.n);
        end
    endtask

    task automatic test_restart();
        snap_t obs, exp;
        drive(0, 1'b1, NOP, obs, exp);
        checks++;
        if (obs !== exp || obs.o[O_DN] !== 1'b1) begin
            errors++;
            $display("FAIL restart_done: got %h want %h", obs, exp);
        end
        drive(0, 1'b0, NOP, obs, exp);
        checks++;
        if (obs !== exp || obs.o[O_DN] !== 1'b0 || obs.o[O_PCI] !== 1'b1) begin
            errors++;
            $display("FAIL restart_init: got %h want %h", obs, exp);
        end
        drive(0, 1'b0, randAlu(), obs, exp);
        checks++;
        if (obs !== exp || obs.o[O_PCE] !== 1'b1 || obs.c !== 16'd0) begin
            errors++;
            $display("FAIL restart_run: got %h want %h", obs, exp);
        end
        drive(0, 1'b0, HALT, obs, exp);
    endtask

    task automatic test_random(input int i, input int n);
        snap_t obs, exp;
        logic [6:0] d;
        logic st;
        d = NOP;
        launch(i);
        for (int k = 0; k < n; k++) begin
            // dec_* stays put while an access is outstanding
            if (!(mMode[i] == 2 && mElapsed[i] > 0)) begin
                case ($urandom_range(0, 9))
                    0, 1, 2, 3: d = randAlu();
                    4, 5:       d = LOAD | (7'($urandom) & 7'b0000011);
                    6, 7:       d = STORE;
                    8:          d = HALT;
                    default:    d = 7'($urandom);
                endcase
            end
            if (mMode[i] == 0 || mMode[i] == 3) st = 1'b1;
            else if (mMode[i] == 1)            st = ($urandom_range(0, 3) == 0);
            else                                st = ($urandom_range(0, 24) == 0);
            drive(i, st, d, obs, exp);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL rand%0d cyc%0d: got %h want %h", i, k, obs, exp);
            end
        end
    endtask

    task automatic test_async_reset();
        snap_t obs, exp;
        startB = 1'b0;
        decB = NOP;
        launch(0);
        drive(0, 1'b0, LOAD, obs, exp);
        @(negedge CLK);
        startA = 1'b0;
        decA = LOAD;
        #1;
        checks++;
        if (outA !== modelOut(0, 1'b0, LOAD) || outA[O_ST] !== 1'b1) begin
            errors++;
            $display("FAIL areset_pre: got %b want %b", outA, modelOut(0, 1'b0, LOAD));
        end
        #1 Reset = 1'b0;
        #1;
        checks++;
        if (outA !== 9'd0 || cycA !== 16'd0 || insA !== 16'd0) begin
            errors++;
            $display("FAIL areset_now: got out=%b cyc=%0d ins=%0d want all 0", outA, cycA, insA);
        end
        modelReset();
        decA = NOP;
        @(posedge CLK);
        #2 Reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(0, 1'b0, LOAD, obs, exp);
            checks++;
            if (obs !== exp || obs.o !== 9'd0) begin
                errors++;
                $display("FAIL areset_idle cyc%0d: got %h want %h", k, obs, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_start_run();
        test_mem(LOAD, 3'b111, 3'b000, 3'b100);
        test_mem(STORE, 3'b000, 3'b001, 3'b000);
        test_zero_lat();
        test_abort();
        test_saturate();
        test_restart();
        test_random(0, 300);
        test_random(1, 300);
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/exec_sequencer.md
# exec_sequencer

Multi-cycle run controller between the instruction decoder and the accumulator datapath. It owns the start/done handshake with the test harness and PC initialisation. It gates the decoder's write and memory enables so that each instruction commits exactly once, and it stalls the PC for data-memory ops with a fixed multi-cycle latency. It also maintains cycle and retired-instruction counters for performance reporting.

## Interface
- MEM_LAT, default 2: data-memory access latency in cycles; legal range 0..15.
- CNT_W, default 16: width of cycle_count and instr_count.

- CLK  in  1  system clock; all state changes on its rising edge.
- Reset  in  1  asynchronous, active-low reset.
- start  in  1  harness request. A high level holds the machine in INIT; the falling edge begins execution.
- dec_RegWrite, dec_AccWrite, dec_ReadMem, dec_WriteMem, dec_Halt, dec_Branch, dec_of0  in  1 each  raw decoder outputs for the current instruction.
- pc_init  out  1  load PC with 0.
- pc_en  out  1  advance PC (PC+1, or branch target when dec_Branch).
- reg_we, acc_we  out  1 each  qualified register-file / accumulator write enables.
- mem_re, mem_we  out  1 each  qualified data-memory read/write strobes.
- of_clr  out  1  qualified overflow-flag clear.
- stall  out  1  high while an access is in progress and the PC is frozen.
- done  out  1  program halted.
- cycle_count  out  CNT_W  cycles spent in RUN and MEMWAIT.
- instr_count  out  CNT_W  retired instructions, including halt.

## Operation
- States: IDLE, INIT, RUN, MEMWAIT, DONE. Encoding is free.
- Reset (async, Reset=0): state=IDLE, wait_cnt=0, both counters=0. All outputs are 0 while in reset.
- IDLE: all outputs 0. start=1 → INIT.
- INIT: pc_init=1, counters cleared. Stays while start=1; start=0 → RUN.
- RUN, dec_Halt=1:
  - Enables 0, pc_en=0.
  - instr_count+1; → DONE.
- RUN, memory op (dec_ReadMem|dec_WriteMem) with MEM_LAT≥1:
  - mem_re=dec_ReadMem, mem_we=dec_WriteMem, stall=1.
  - acc_we=reg_we=pc_en=0.
  - wait_cnt←1; → MEMWAIT.
- RUN, other ops, or memory op with MEM_LAT=0:
  - reg_we/acc_we/mem_re/mem_we/of_clr pass the dec_* values; pc_en=1.
  - instr_count+1; stay in RUN.
- MEMWAIT, wait_cnt<MEM_LAT:
  - mem_re=dec_ReadMem; mem_we=0 (store strobe fires exactly once); stall=1; pc_en=0.
  - wait_cnt+1.
- MEMWAIT, wait_cnt==MEM_LAT:
  - mem_re=dec_ReadMem, acc_we=dec_AccWrite, pc_en=1, stall=0.
  - instr_count+1; → RUN.
- DONE: done=1, all other outputs 0, counters hold. start=1 → INIT.
- start=1 in RUN or MEMWAIT: abort. No enables are asserted that cycle; → INIT next edge. start overrides dec_Halt.
- dec_of0, dec_Branch: honoured only on a retiring RUN cycle; never stalled.
- Counters: cycle_count increments on every RUN/MEMWAIT cycle. Both counters saturate at 2^CNT_W−1 and do not wrap.

## Timing
- Enables (reg_we, acc_we, mem_*, of_clr, pc_en) are combinational in state and dec_* (Mealy). They are valid in the same cycle the instruction is decoded.
- pc_init, stall, done are Moore outputs, except that stall also rises in the RUN cycle that enters MEMWAIT.
- Latency:
  - Non-memory instruction: 1 cycle.
  - Memory instruction: MEM_LAT+1 cycles.
  - Halt: 1 cycle; done is high in the following cycle.
- First instruction executes in the cycle after the falling edge of start is sampled.
- dec_* is stable throughout MEMWAIT because the PC is frozen; the block does not latch it.
- Reset mid-MEMWAIT: immediate return to IDLE; the pending access is dropped with no acc_we.

## Test plan
- Reset and idle:
  - Reset low → all outputs 0, counters 0.
  - Release reset with start=0 for 5 cycles → still IDLE, done=0.
- Start and run:
  - start high 3 cycles → pc_init=1 for 3 cycles.
  - Release start; run 4 ALU ops and then halt → pc_en high 4 cycles, done rises on cycle 6, cycle_count=5, instr_count=5.
- Load with MEM_LAT=2:
  - mem_re high 3 cycles, stall high 2 cycles.
  - acc_we and pc_en single pulse on cycle 3; instr_count+1.
- Store with MEM_LAT=2:
  - mem_we exactly one pulse on cycle 1, stall 2 cycles, acc_we never high.
- MEM_LAT=0 build: load/store retire in 1 cycle, stall never asserted.
- Abort, saturation, restart:
  - start asserted mid-MEMWAIT → no acc_we; INIT next cycle, counters cleared.
  - CNT_W=4 with an 20-op program → cycle_count saturates at 15.
  - start from DONE → clean restart, done drops.
